// File: rtl/axis_cobs_frame_arbiter_if.sv
// -----------------------------------------------------------------------------
// axis_cobs_frame_arbiter_if
//   Byte-wide AXI-Stream bundle with LANES parallel lanes. Each lane has its
//   own valid/ready/last/user; lane i's data is at tdata[8i+7:8i].
//   One instance with LANES=NUM_PORTS carries the raw source streams into the
//   arbiter. Another instance with LANES=1 carries the merged stream out to
//   the COBS encoder.
//   Modports:
//     master : drives tdata/tvalid/tlast/tuser, receives tready
//     slave  : receives tdata/tvalid/tlast/tuser, drives tready
// -----------------------------------------------------------------------------
interface axis_cobs_frame_arbiter_if #(
    parameter int unsigned LANES = 1
);
    logic [8*LANES-1:0] tdata;
    logic [LANES-1:0]   tvalid;
    logic [LANES-1:0]   tready;
    logic [LANES-1:0]   tlast;
    logic [LANES-1:0]   tuser;

    modport master (
        output tdata,
        output tvalid,
        output tlast,
        output tuser,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        input  tlast,
        input  tuser,
        output tready
    );
endinterface

// File: rtl/axis_cobs_frame_arbiter.sv
// -----------------------------------------------------------------------------
// axis_cobs_frame_arbiter
//   Packet-level round-robin arbiter. It shares one byte-wide COBS encoder
//   between NUM_PORTS raw AXI-Stream sources. A grant is held from the first
//   beat of a frame through its tlast beat. When HEADER_EN=1, each frame is
//   preceded by a channel-ID byte (ID_BASE + port index, mod 256), so the far
//   end can demultiplex after COBS decoding.
//
//   Ports:
//     clk          shared clock for the sources and the encoder
//     reset        asynchronous, active-high reset
//     s_axis       NUM_PORTS-lane slave bundle from the sources
//     m_axis       single-lane master bundle to the encoder's s_axis
//     grant_id     index of the current or most recently granted port
//     busy         high while a header or frame is being forwarded
//     frame_count  number of completed frames; wraps from 16'hFFFF to 0
//
//   Each frame costs one IDLE arbitration cycle, plus one HEADER beat when
//   HEADER_EN=1. In DATA the granted port is passed straight through
//   combinationally, so the data path adds no latency.
// -----------------------------------------------------------------------------
module axis_cobs_frame_arbiter #(
    parameter int unsigned NUM_PORTS = 4,
    parameter bit          HEADER_EN = 1'b1,
    parameter logic [7:0]  ID_BASE   = 8'h00
) (
    input  logic                            clk,
    input  logic                            reset,
    axis_cobs_frame_arbiter_if.slave        s_axis,
    axis_cobs_frame_arbiter_if.master       m_axis,
    output logic [3:0]                      grant_id,
    output logic                            busy,
    output logic [15:0]                     frame_count
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HEADER = 2'd1,
        ST_DATA   = 2'd2
    } state_t;

    // Starting last_grant at the highest port makes port 0 win first after reset.
    localparam logic [3:0] LAST_PORT = 4'(NUM_PORTS - 1);

    state_t         state_q;
    logic [3:0]     grant_q;
    logic [3:0]     last_grant_q;
    logic           busy_q;
    logic [15:0]    frame_count_q;

    logic [3:0]     grant_d;
    logic           req_found_s;
    logic [15:0]    frame_count_d;

    logic [7:0]     sel_tdata_s;
    logic           sel_tvalid_s;
    logic           sel_tlast_s;
    logic           sel_tuser_s;

    logic [7:0]     m_tdata_s;
    logic           m_tvalid_s;
    logic           m_tlast_s;
    logic           m_tuser_s;
    logic [NUM_PORTS-1:0] s_tready_s;

    logic           data_done_s;

    // Round-robin search: first requester above last_grant, otherwise the
    // lowest-indexed requester (this is the wrap-around part of the search).
    always_comb begin
        logic hit_s;
        req_found_s = 1'b0;
        grant_d     = 4'h0;
        hit_s       = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            hit_s       = !req_found_s && s_axis.tvalid[i] && (4'(i) > last_grant_q);
            grant_d     = hit_s ? 4'(i) : grant_d;
            req_found_s = req_found_s | hit_s;
        end
        for (int i = 0; i < NUM_PORTS; i++) begin
            hit_s       = !req_found_s && s_axis.tvalid[i];
            grant_d     = hit_s ? 4'(i) : grant_d;
            req_found_s = req_found_s | hit_s;
        end
    end

    // Select the granted lane with an AND-OR mux; grant_q is always a valid port index.
    always_comb begin
        logic sel_hit_s;
        sel_tdata_s  = 8'h00;
        sel_tvalid_s = 1'b0;
        sel_tlast_s  = 1'b0;
        sel_tuser_s  = 1'b0;
        sel_hit_s    = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            sel_hit_s    = (grant_q == 4'(i));
            sel_tdata_s  = sel_tdata_s  | (sel_hit_s ? s_axis.tdata[8*i +: 8] : 8'h00);
            sel_tvalid_s = sel_tvalid_s | (sel_hit_s & s_axis.tvalid[i]);
            sel_tlast_s  = sel_tlast_s  | (sel_hit_s & s_axis.tlast[i]);
            sel_tuser_s  = sel_tuser_s  | (sel_hit_s & s_axis.tuser[i]);
        end
    end

    // Output stage: idle outputs in IDLE, the ID byte in HEADER, and pass-through of the granted port in DATA.
    always_comb begin
        m_tdata_s  = 8'h00;
        m_tvalid_s = 1'b0;
        m_tlast_s  = 1'b0;
        m_tuser_s  = 1'b0;
        s_tready_s = {NUM_PORTS{1'b0}};
        case (state_q)
            ST_IDLE: begin
                m_tvalid_s = 1'b0;
            end
            ST_HEADER: begin
                m_tvalid_s = 1'b1;
                m_tdata_s  = ID_BASE + {4'h0, grant_q};
            end
            ST_DATA: begin
                m_tdata_s  = sel_tdata_s;
                m_tvalid_s = sel_tvalid_s;
                m_tlast_s  = sel_tlast_s;
                m_tuser_s  = sel_tuser_s;
                for (int i = 0; i < NUM_PORTS; i++) begin
                    s_tready_s[i] = (grant_q == 4'(i)) & m_axis.tready[0];
                end
            end
            default: begin
                m_tvalid_s = 1'b0;
            end
        endcase
    end

    // A frame ends on the handshake of the granted port's tlast beat.
    always_comb begin
        data_done_s   = (state_q == ST_DATA) & sel_tvalid_s & sel_tlast_s & m_axis.tready[0];
        frame_count_d = frame_count_q + 16'd1;
    end

    // Arbitration FSM. The grant is latched in IDLE and held until the frame's last beat.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            grant_q       <= 4'h0;
            last_grant_q  <= LAST_PORT;
            busy_q        <= 1'b0;
            frame_count_q <= 16'h0000;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_found_s) begin
                        grant_q <= grant_d;
                        busy_q  <= 1'b1;
                        state_q <= HEADER_EN ? ST_HEADER : ST_DATA;
                    end
                end
                ST_HEADER: begin
                    if (m_axis.tready[0]) begin
                        state_q <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (data_done_s) begin
                        last_grant_q  <= grant_q;
                        frame_count_q <= frame_count_d;
                        busy_q        <= 1'b0;
                        state_q       <= ST_IDLE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign m_axis.tdata  = m_tdata_s;
    assign m_axis.tvalid = m_tvalid_s;
    assign m_axis.tlast  = m_tlast_s;
    assign m_axis.tuser  = m_tuser_s;
    assign s_axis.tready = s_tready_s;

    assign grant_id    = grant_q;
    assign busy        = busy_q;
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_axis_cobs_frame_arbiter.sv
// -----------------------------------------------------------------------------
// tb_axis_cobs_frame_arbiter
//   Directed bench for two arbiter instances:
//     A: 4 ports, ID header enabled, ID_BASE 8'h00
//     B: 4 ports, no header,         ID_BASE 8'hF0
//   Source beats are loaded into per-port queues. The expected output beats
//   are pushed onto a per-instance scoreboard at the same time and are popped
//   whenever the encoder-side handshake fires.
// -----------------------------------------------------------------------------
module tb_axis_cobs_frame_arbiter;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    axis_cobs_frame_arbiter_if #(.LANES(4)) sa ();
    axis_cobs_frame_arbiter_if #(.LANES(1)) ma ();
    axis_cobs_frame_arbiter_if #(.LANES(4)) sb ();
    axis_cobs_frame_arbiter_if #(.LANES(1)) mb ();

    logic [3:0]  grant_a, grant_b;
    logic        busy_a, busy_b;
    logic [15:0] fc_a, fc_b;

    axis_cobs_frame_arbiter #(.NUM_PORTS(4), .HEADER_EN(1'b1), .ID_BASE(8'h00)) u_dut_a (
        .clk(clk), .reset(reset), .s_axis(sa), .m_axis(ma),
        .grant_id(grant_a), .busy(busy_a), .frame_count(fc_a)
    );

    axis_cobs_frame_arbiter #(.NUM_PORTS(4), .HEADER_EN(1'b0), .ID_BASE(8'hF0)) u_dut_b (
        .clk(clk), .reset(reset), .s_axis(sb), .m_axis(mb),
        .grant_id(grant_b), .busy(busy_b), .frame_count(fc_b)
    );

    int checks = 0;
    int passes = 0;

    logic [9:0] src_q [2][4][$];   // {user, last, data}
    logic [9:0] sb_q  [2][$];
    int         pause_c [2][4];
    bit         bp_en = 1'b0;
    bit         prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    endtask

    function automatic logic [9:0] bt(input logic [7:0] d, input logic l, input logic u);
        return {u, l, d};
    endfunction

    // Present each port's queue head, unless the port is paused.
    task automatic drive();
        logic [31:0] td;
        logic [3:0]  tv, tl, tu;
        logic [9:0]  h;
        for (int d = 0; d < 2; d++) begin
            td = 32'h0; tv = 4'h0; tl = 4'h0; tu = 4'h0;
            for (int i = 0; i < 4; i++) begin
                if (src_q[d][i].size() > 0 && pause_c[d][i] == 0) begin
                    h = src_q[d][i][0];
                    td[8*i +: 8] = h[7:0];
                    tv[i] = 1'b1;
                    tl[i] = h[8];
                    tu[i] = h[9];
                end
            end
            if (d == 0) begin
                sa.tdata = td; sa.tvalid = tv; sa.tlast = tl; sa.tuser = tu;
            end else begin
                sb.tdata = td; sb.tvalid = tv; sb.tlast = tl; sb.tuser = tu;
            end
        end
    endtask

    task automatic settle();
        drive();
        #1;
    endtask

    task automatic monitor(input int d, input logic [7:0] data, input logic last, input logic user);
        logic [9:0] e;
        chk($sformatf("beat_expected_d%0d", d), 32'(sb_q[d].size() > 0), 32'd1);
        if (sb_q[d].size() > 0) begin
            e = sb_q[d].pop_front();
            chk($sformatf("beat_d%0d", d), 32'({user, last, data}), 32'(e));
        end
    endtask

    // One clock: check the beats that handshake on this edge, then advance the sources.
    task automatic tick();
        logic [3:0] hs_a, hs_b;
        hs_a = sa.tvalid & sa.tready;
        hs_b = sb.tvalid & sb.tready;
        if (ma.tvalid[0] && ma.tready[0]) monitor(0, ma.tdata, ma.tlast[0], ma.tuser[0]);
        if (mb.tvalid[0] && mb.tready[0]) monitor(1, mb.tdata, mb.tlast[0], mb.tuser[0]);
        if (sa.tready != 4'h0) chk("ready_onehot", 32'($onehot0(sa.tready)), 32'd1);
        if (prev_stall) chk("hold_when_stalled", 32'({ma.tvalid[0], ma.tdata}), 32'({1'b1, prev_data}));
        prev_stall = ma.tvalid[0] & ~ma.tready[0];
        prev_data  = ma.tdata;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (hs_a[i]) void'(src_q[0][i].pop_front());
            if (hs_b[i]) void'(src_q[1][i].pop_front());
            for (int d = 0; d < 2; d++) begin
                if (pause_c[d][i] > 0) pause_c[d][i]--;
            end
        end
        ma.tready[0] = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
        settle();
    endtask

    task automatic drain(input int d, input int budget, input string tag, output int n);
        n = 0;
        while (sb_q[d].size() > 0 && n < budget) begin
            tick();
            n++;
        end
        chk(tag, 32'(sb_q[d].size()), 32'd0);
    endtask

    // Load a frame into a source queue, and push the expected header and beats onto the scoreboard.
    task automatic load_frame(input int d, input int p, input logic [7:0] base, input int len,
                              input logic [7:0] step, input bit hdr, input logic [7:0] id);
        logic [7:0] v;
        if (hdr) sb_q[d].push_back(bt(id, 1'b0, 1'b0));
        for (int k = 0; k < len; k++) begin
            v = base + 8'(k) * step;
            src_q[d][p].push_back(bt(v, (k == len - 1), 1'b0));
            sb_q[d].push_back(bt(v, (k == len - 1), 1'b0));
        end
    endtask

    task automatic reset_pulse();
        reset = 1'b1;
        #1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        settle();
    endtask

    initial begin
        int n;
        ma.tready = 1'b1;
        mb.tready = 1'b1;
        for (int d = 0; d < 2; d++) for (int i = 0; i < 4; i++) pause_c[d][i] = 0;
        settle();

        // Reset state
        chk("rst_m_tvalid", 32'(ma.tvalid), 32'd0);
        chk("rst_m_tdata",  32'(ma.tdata),  32'd0);
        chk("rst_m_tlast",  32'({ma.tlast, ma.tuser}), 32'd0);
        chk("rst_s_tready", 32'(sa.tready), 32'd0);
        chk("rst_busy",     32'(busy_a),    32'd0);
        chk("rst_grant",    32'(grant_a),   32'd0);
        chk("rst_fc",       32'(fc_a),      32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        settle();
        tick(); tick();
        chk("idle_no_req_busy", 32'(busy_a), 32'd0);

        // Test 1: port 2 sends 11 22 33 -> 02 11 22 33
        load_frame(0, 2, 8'h11, 3, 8'h11, 1'b1, 8'h02);
        settle();
        drain(0, 50, "t1_drain", n);
        chk("t1_fc",    32'(fc_a),    32'd1);
        chk("t1_grant", 32'(grant_a), 32'd2);
        chk("t1_busy",  32'(busy_a),  32'd0);

        // Test 2: ports 0,1,3 together, port 0 re-requests -> order 0,1,3,0
        reset_pulse();
        chk("t2_fc_after_reset", 32'(fc_a), 32'd0);
        load_frame(0, 0, 8'hA0, 2, 8'h01, 1'b1, 8'h00);
        load_frame(0, 1, 8'hB0, 2, 8'h01, 1'b1, 8'h01);
        load_frame(0, 3, 8'hD0, 2, 8'h01, 1'b1, 8'h03);
        load_frame(0, 0, 8'hC0, 2, 8'h01, 1'b1, 8'h00);
        settle();
        drain(0, 100, "t2_drain", n);
        chk("t2_fc",    32'(fc_a),    32'd4);
        chk("t2_grant", 32'(grant_a), 32'd0);

        // Test 3: 64-byte frame from port 2 under random backpressure
        bp_en = 1'b1;
        load_frame(0, 2, 8'h03, 64, 8'h07, 1'b1, 8'h02);
        settle();
        drain(0, 3000, "t3_drain", n);
        bp_en = 1'b0;
        ma.tready = 1'b1;
        prev_stall = 1'b0;
        tick();
        chk("t3_fc", 32'(fc_a), 32'd5);

        // Test 4: port 3 stalls for 5 cycles mid-frame while port 1 waits
        load_frame(0, 3, 8'h40, 8, 8'h01, 1'b1, 8'h03);
        load_frame(0, 1, 8'h90, 2, 8'h01, 1'b1, 8'h01);
        settle();
        n = 0;
        while (src_q[0][3].size() != 4 && n < 50) begin tick(); n++; end
        chk("t4_sync", 32'(src_q[0][3].size()), 32'd4);
        pause_c[0][3] = 5;
        settle();
        for (int k = 0; k < 5; k++) begin
            chk("t4_gap_tvalid", 32'(ma.tvalid), 32'd0);
            chk("t4_gap_grant",  32'(grant_a),   32'd3);
            chk("t4_p1_ready",   32'(sa.tready[1]), 32'd0);
            tick();
        end
        chk("t4_resume_tvalid", 32'(ma.tvalid), 32'd1);
        drain(0, 100, "t4_drain", n);
        chk("t4_fc",    32'(fc_a),    32'd7);
        chk("t4_grant", 32'(grant_a), 32'd1);

        // Test 5: reset while byte 10 of a 20-byte frame is on the bus
        load_frame(0, 1, 8'hC0, 20, 8'h01, 1'b1, 8'h01);
        settle();
        n = 0;
        while (src_q[0][1].size() != 11 && n < 60) begin tick(); n++; end
        chk("t5_sync",      32'(src_q[0][1].size()), 32'd11);
        chk("t5_byte10",    32'({ma.tvalid[0], ma.tdata}), 32'({1'b1, 8'hC9}));
        reset = 1'b1;
        #1;
        chk("t5_rst_tvalid", 32'(ma.tvalid), 32'd0);
        chk("t5_rst_tready", 32'(sa.tready), 32'd0);
        chk("t5_rst_busy",   32'(busy_a),    32'd0);
        chk("t5_rst_fc",     32'(fc_a),      32'd0);
        sb_q[0].delete();
        @(posedge clk); #1;
        reset = 1'b0;
        load_frame(0, 0, 8'hE0, 1, 8'h01, 1'b1, 8'h00);
        sb_q[0].push_back(bt(8'h01, 1'b0, 1'b0));
        for (int k = 9; k < 20; k++) sb_q[0].push_back(bt(8'hC0 + 8'(k), (k == 19), 1'b0));
        settle();
        drain(0, 100, "t5_drain", n);
        chk("t5_fc", 32'(fc_a), 32'd2);

        // Test 6: no header, single-beat frames from port 1 at two cycles each
        src_q[1][1].push_back(bt(8'h5A, 1'b1, 1'b0));
        src_q[1][1].push_back(bt(8'h6B, 1'b1, 1'b1));
        src_q[1][1].push_back(bt(8'h7C, 1'b1, 1'b0));
        sb_q[1].push_back(bt(8'h5A, 1'b1, 1'b0));
        sb_q[1].push_back(bt(8'h6B, 1'b1, 1'b1));
        sb_q[1].push_back(bt(8'h7C, 1'b1, 1'b0));
        settle();
        drain(1, 50, "t6_drain", n);
        chk("t6_cycles", 32'(n),       32'd6);
        chk("t6_fc",     32'(fc_b),    32'd3);
        chk("t6_grant",  32'(grant_b), 32'd1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
